fu_wb_arbiter: RTL and testbench

Write-back stage directly downstream of the functional units (FU_mem, ALU, mul, div, jump), consuming each FU's one-cycle finish pulse and result.
- Captures each result into a per-FU holding slot.
- Grants exactly one register-file write per cycle using round-robin arbitration.
- Exports per-FU slot occupancy so the scoreboard can stall issue to an FU whose result has not yet retired.

---
 rtl/fu_wb_arbiter.sv | 111 +++++++++++
 tb/tb_fu_wb_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_wb_arbiter.sv
// Write-back arbiter: one holding slot per functional unit and a round-robin grant of a single
// register-file write per cycle.
module fu_wb_arbiter #(
    parameter int unsigned NUM_FU = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned IDX_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_FU-1:0]        fu_finish,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    input  logic [NUM_FU*RD_W-1:0]   fu_rd,
    output logic                     wb_en,
    output logic [RD_W-1:0]          wb_rd,
    output logic [DATA_W-1:0]        wb_data,
    output logic [IDX_W-1:0]         wb_fu,
    output logic [NUM_FU-1:0]        fu_hold,
    output logic                     overflow
);

    localparam logic [IDX_W:0]   NumFu   = (IDX_W+1)'(NUM_FU);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_FU - 1);

    logic [NUM_FU-1:0] valid_q, valid_d;
    logic [DATA_W-1:0] data_q [NUM_FU];
    logic [RD_W-1:0]   rd_q   [NUM_FU];
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              overflow_q, overflow_d;

    logic              gnt_valid;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W:0]    cand;
    logic [NUM_FU-1:0] gnt_oh;
    logic [NUM_FU-1:0] cap;
    logic [NUM_FU-1:0] load;

    // Round-robin search starting at rr_ptr over the registered slot state only.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= NumFu) begin
                cand = cand - NumFu;
            end
            if (!gnt_valid && valid_q[cand[IDX_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_oh     = gnt_valid ? (NUM_FU'(1) << gnt_idx) : '0;
        valid_d    = valid_q;
        rr_ptr_d   = rr_ptr_q;
        overflow_d = overflow_q;
        cap        = '0;
        load       = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            // rd == 0 targets x0: the result is silently discarded.
            cap[i] = fu_finish[i] && (fu_rd[i*RD_W +: RD_W] != '0);
            if (cap[i] && (!valid_q[i] || gnt_oh[i])) begin
                load[i]    = 1'b1;
                valid_d[i] = 1'b1;
            end else if (gnt_oh[i]) begin
                valid_d[i] = 1'b0;
            end
            if (cap[i] && valid_q[i] && !gnt_oh[i]) begin
                overflow_d = 1'b1;
            end
        end
        if (gnt_valid) begin
            rr_ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            rr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload needs no reset; it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (load[i]) begin
                data_q[i] <= fu_data[i*DATA_W +: DATA_W];
                rd_q[i]   <= fu_rd[i*RD_W +: RD_W];
            end
        end
    end

    always_comb begin
        wb_en    = gnt_valid;
        wb_fu    = gnt_idx;
        wb_rd    = gnt_valid ? rd_q[gnt_idx] : '0;
        wb_data  = gnt_valid ? data_q[gnt_idx] : '0;
        fu_hold  = valid_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Bench for fu_wb_arbiter: directed scenarios from the test plan plus a randomized run checked
// against a slot-level behavioural model.
module tb_fu_wb_arbiter;

    localparam int NUM_FU = 5;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int IDX_W  = 3;

    logic                     clk;
    logic                     rst;
    logic [NUM_FU-1:0]        fu_finish;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU*RD_W-1:0]   fu_rd;
    logic                     wb_en;
    logic [RD_W-1:0]          wb_rd;
    logic [DATA_W-1:0]        wb_data;
    logic [IDX_W-1:0]         wb_fu;
    logic [NUM_FU-1:0]        fu_hold;
    logic                     overflow;

    int compared;
    int mismatched;

    fu_wb_arbiter #(
        .NUM_FU(NUM_FU),
        .DATA_W(DATA_W),
        .RD_W  (RD_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fu_finish(fu_finish),
        .fu_data  (fu_data),
        .fu_rd    (fu_rd),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .wb_fu    (wb_fu),
        .fu_hold  (fu_hold),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: slot contents, next-search start, sticky error.
    bit          m_valid [NUM_FU];
    logic [31:0] m_data  [NUM_FU];
    logic [4:0]  m_rd    [NUM_FU];
    int          m_ptr;
    bit          m_ovf;

    task automatic clear_inputs();
        fu_finish = '0;
        fu_data   = '0;
        fu_rd     = '0;
    endtask

    task automatic set_fu(input int i, input logic [4:0] rd, input logic [31:0] d);
        fu_finish[i]                = 1'b1;
        fu_rd[i*RD_W +: RD_W]       = rd;
        fu_data[i*DATA_W +: DATA_W] = d;
    endtask

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        for (int i = 0; i < NUM_FU; i++) m_valid[i] = 0;
        m_ptr = 0;
        m_ovf = 0;
    endtask

    // Grant is the first occupied slot found scanning from m_ptr with wrap-around.
    function automatic int model_grant();
        for (int k = 0; k < NUM_FU; k++) begin
            if (m_valid[(m_ptr + k) % NUM_FU]) return (m_ptr + k) % NUM_FU;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [NUM_FU-1:0] fin, input logic [NUM_FU*RD_W-1:0] rds,
                              input logic [NUM_FU*DATA_W-1:0] ds);
        int g;
        g = model_grant();
        if (g >= 0) begin
            m_valid[g] = 0;
            m_ptr = (g + 1) % NUM_FU;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (fin[i] && rds[i*RD_W +: RD_W] != 0) begin
                if (m_valid[i]) begin
                    m_ovf = 1;
                end else begin
                    m_valid[i] = 1;
                    m_rd[i]    = rds[i*RD_W +: RD_W];
                    m_data[i]  = ds[i*DATA_W +: DATA_W];
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            compared++;
            if (wb_en !== 1'b0 || fu_hold !== 5'b0 || overflow !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_idle cycle %0d: wb_en=%b fu_hold=%b overflow=%b, want 0/00000/0",
                         c, wb_en, fu_hold, overflow);
            end
            tick();
        end
        set_fu(1, 5'd2, 32'h1);
        set_fu(3, 5'd4, 32'h3);
        tick();
        clear_inputs();
        compared++;
        if (fu_hold !== 5'b01010) begin
            mismatched++;
            $display("FAIL reset_preload: fu_hold=%b want 01010", fu_hold);
        end
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (fu_hold !== 5'b0 || wb_en !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 ||
            wb_fu !== 3'd0 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_async: hold=%b en=%b rd=%0d data=%h fu=%0d ovf=%b, want all zero",
                     fu_hold, wb_en, wb_rd, wb_data, wb_fu, overflow);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        compared++;
        if (fu_hold !== 5'b0 || wb_en !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_discard: hold=%b en=%b want 00000/0", fu_hold, wb_en);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_fu(1, 5'd7, 32'hDEADBEEF);
        tick();
        clear_inputs();
        compared++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'hDEADBEEF || wb_fu !== 3'd1 ||
            fu_hold !== 5'b00010) begin
            mismatched++;
            $display("FAIL single_wb: en=%b rd=%0d data=%h fu=%0d hold=%b want 1/7/deadbeef/1/00010",
                     wb_en, wb_rd, wb_data, wb_fu, fu_hold);
        end
        tick();
        compared++;
        if (wb_en !== 1'b0 || fu_hold !== 5'b0) begin
            mismatched++;
            $display("FAIL single_done: en=%b hold=%b want 0/00000", wb_en, fu_hold);
        end
    endtask

    task automatic test_all_five();
        do_reset();
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 5'(i + 1), 32'((i + 1) * 16));
        tick();
        clear_inputs();
        for (int k = 0; k < NUM_FU; k++) begin
            compared++;
            if (wb_en !== 1'b1 || wb_fu !== 3'(k) || wb_rd !== 5'(k + 1) ||
                wb_data !== 32'((k + 1) * 16)) begin
                mismatched++;
                $display("FAIL all_five step %0d: en=%b fu=%0d rd=%0d data=%h want 1/%0d/%0d/%h",
                         k, wb_en, wb_fu, wb_rd, wb_data, k, k + 1, (k + 1) * 16);
            end
            tick();
        end
        compared++;
        if (wb_en !== 1'b0 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL all_five_empty: en=%b ovf=%b want 0/0", wb_en, overflow);
        end
        // Pointer should be back at 0: FU0 beats FU4.
        set_fu(0, 5'd10, 32'hA0);
        set_fu(4, 5'd14, 32'hA4);
        tick();
        clear_inputs();
        compared++;
        if (wb_fu !== 3'd0 || wb_rd !== 5'd10) begin
            mismatched++;
            $display("FAIL all_five_ptr: fu=%0d rd=%0d want 0/10", wb_fu, wb_rd);
        end
        repeat (2) tick();
    endtask

    task automatic test_rr_fairness();
        do_reset();
        set_fu(1, 5'd1, 32'h1);
        tick();
        clear_inputs();
        // FU1 retires at this edge, leaving the pointer at 2.
        set_fu(0, 5'd20, 32'h100);
        set_fu(3, 5'd23, 32'h300);
        tick();
        clear_inputs();
        compared++;
        if (wb_en !== 1'b1 || wb_fu !== 3'd3 || wb_rd !== 5'd23) begin
            mismatched++;
            $display("FAIL rr_first: en=%b fu=%0d rd=%0d want 1/3/23", wb_en, wb_fu, wb_rd);
        end
        tick();
        compared++;
        if (wb_en !== 1'b1 || wb_fu !== 3'd0 || wb_rd !== 5'd20) begin
            mismatched++;
            $display("FAIL rr_second: en=%b fu=%0d rd=%0d want 1/0/20", wb_en, wb_fu, wb_rd);
        end
        tick();
    endtask

    task automatic test_rd_zero();
        do_reset();
        set_fu(2, 5'd0, 32'h1234);
        tick();
        clear_inputs();
        compared++;
        if (wb_en !== 1'b0 || fu_hold[2] !== 1'b0 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL rd_zero: en=%b hold2=%b ovf=%b want 0/0/0", wb_en, fu_hold[2], overflow);
        end
    endtask

    task automatic test_drain_refill();
        do_reset();
        set_fu(2, 5'd3, 32'h55);
        tick();
        clear_inputs();
        set_fu(2, 5'd9, 32'hAA);
        compared++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h55) begin
            mismatched++;
            $display("FAIL refill_first: en=%b rd=%0d data=%h want 1/3/55", wb_en, wb_rd, wb_data);
        end
        tick();
        clear_inputs();
        compared++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'hAA || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL refill_second: en=%b rd=%0d data=%h ovf=%b want 1/9/aa/0",
                     wb_en, wb_rd, wb_data, overflow);
        end
        tick();
    endtask

    task automatic test_collision();
        do_reset();
        set_fu(0, 5'd4, 32'h11);
        set_fu(2, 5'd3, 32'h55);
        tick();
        clear_inputs();
        // FU0 holds the grant, so this second FU2 result collides.
        set_fu(2, 5'd9, 32'hAA);
        tick();
        clear_inputs();
        compared++;
        if (overflow !== 1'b1 || wb_en !== 1'b1 || wb_fu !== 3'd2 || wb_rd !== 5'd3 ||
            wb_data !== 32'h55) begin
            mismatched++;
            $display("FAIL collision: ovf=%b en=%b fu=%0d rd=%0d data=%h want 1/1/2/3/55",
                     overflow, wb_en, wb_fu, wb_rd, wb_data);
        end
        repeat (3) tick();
        compared++;
        if (overflow !== 1'b1 || wb_en !== 1'b0) begin
            mismatched++;
            $display("FAIL collision_sticky: ovf=%b en=%b want 1/0", overflow, wb_en);
        end
    endtask

    task automatic test_random();
        int g;
        logic [NUM_FU-1:0] fin;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            g = model_grant();
            compared++;
            if (g < 0) begin
                if (wb_en !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || wb_fu !== 3'd0) begin
                    mismatched++;
                    $display("FAIL random_idle cycle %0d: en=%b rd=%0d data=%h fu=%0d want all zero",
                             c, wb_en, wb_rd, wb_data, wb_fu);
                end
            end else if (wb_en !== 1'b1 || wb_fu !== 3'(g) || wb_rd !== m_rd[g] ||
                         wb_data !== m_data[g]) begin
                mismatched++;
                $display("FAIL random_wb cycle %0d: en=%b fu=%0d rd=%0d data=%h want 1/%0d/%0d/%h",
                         c, wb_en, wb_fu, wb_rd, wb_data, g, m_rd[g], m_data[g]);
            end
            compared++;
            for (int i = 0; i < NUM_FU; i++) fin[i] = m_valid[i];
            if (fu_hold !== fin || overflow !== m_ovf) begin
                mismatched++;
                $display("FAIL random_state cycle %0d: hold=%b ovf=%b want %b/%b",
                         c, fu_hold, overflow, fin, m_ovf);
            end
            clear_inputs();
            for (int i = 0; i < NUM_FU; i++) begin
                if ($urandom_range(0, 99) < 25) begin
                    set_fu(i, 5'($urandom_range(0, 31)), $urandom);
                end
            end
            model_step(fu_finish, fu_rd, fu_data);
            tick();
            if (c == 250) begin
                do_reset();
            end
        end
        clear_inputs();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_all_five();
        test_rr_fairness();
        test_rd_zero();
        test_drain_refill();
        test_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
